// File: rtl/booth_decoder.sv
// Radix-4 Booth partial-product selector with a registered output and a valid strobe.
// Define BOOTH_INV_ONLY_EN to emit only ~M / ~2M on negative picks; downstream adds the +1.
module booth_decoder #(
  parameter int IN_W  = 23,
  parameter int OUT_W = IN_W + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  input  logic [2:0]       code,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             neg
);

  localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  // Negation of the selected magnitude. The inverse-only build leaves the +1 to the adder tree.
  function automatic logic [OUT_W-1:0] negate(input logic [OUT_W-1:0] v);
`ifdef BOOTH_INV_ONLY_EN
    negate = ~v;
`else
    negate = ~v + ONE;
`endif
  endfunction

  logic [OUT_W-1:0] m_ext;
  logic [OUT_W-1:0] m_dbl;
  logic [OUT_W-1:0] sel_mag;
  logic             sel_neg;
  logic [OUT_W-1:0] pp;

  // Booth group decode into a magnitude choice and sign.
  always_comb begin
    m_ext   = {{(OUT_W-IN_W){1'b0}}, in};
    m_dbl   = {m_ext[OUT_W-2:0], 1'b0};
    sel_mag = {OUT_W{1'b0}};
    sel_neg = 1'b0;
    case (code)
      3'b000: begin sel_mag = {OUT_W{1'b0}}; sel_neg = 1'b0; end
      3'b001: begin sel_mag = m_ext;         sel_neg = 1'b0; end
      3'b010: begin sel_mag = m_ext;         sel_neg = 1'b0; end
      3'b011: begin sel_mag = m_dbl;         sel_neg = 1'b0; end
      3'b100: begin sel_mag = m_dbl;         sel_neg = 1'b1; end
      3'b101: begin sel_mag = m_ext;         sel_neg = 1'b1; end
      3'b110: begin sel_mag = m_ext;         sel_neg = 1'b1; end
      3'b111: begin sel_mag = {OUT_W{1'b0}}; sel_neg = 1'b0; end
      default: begin sel_mag = {OUT_W{1'b0}}; sel_neg = 1'b0; end
    endcase
    if (sel_neg) begin
      pp = negate(sel_mag);
    end else begin
      pp = sel_mag;
    end
  end

  // Output register; out/neg hold while no input is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= {OUT_W{1'b0}};
      neg       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= pp;
        neg <= sel_neg;
      end
    end
  end

endmodule

// File: tb/tb_booth_decoder.sv
// Directed self-checking bench for booth_decoder (default and BOOTH_INV_ONLY_EN builds).
module tb_booth_decoder;

  localparam int IN_W  = 23;
  localparam int OUT_W = 26;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [IN_W-1:0]  in;
  logic [2:0]       code;
  logic             out_valid;
  logic [OUT_W-1:0] out;
  logic             neg;

  int tests;
  int fails;

`ifdef BOOTH_INV_ONLY_EN
  localparam logic [OUT_W-1:0] NEG_M   = 26'h3FA50F3;
  localparam logic [OUT_W-1:0] NEG_2M  = 26'h3F4A1E7;
  localparam logic [OUT_W-1:0] NEG_2MX = 26'h3000001;
`else
  localparam logic [OUT_W-1:0] NEG_M   = 26'h3FA50F4;
  localparam logic [OUT_W-1:0] NEG_2M  = 26'h3F4A1E8;
  localparam logic [OUT_W-1:0] NEG_2MX = 26'h3000002;
`endif
  localparam logic [IN_W-1:0]  M0 = 23'h05AF0C;
  localparam logic [IN_W-1:0]  MX = 23'h7FFFFF;

  booth_decoder #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .code(code),
    .out_valid(out_valid), .out(out), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge, then settle just after the next rising edge.
  task automatic drive(input logic v, input logic [IN_W-1:0] m, input logic [2:0] c);
    @(negedge clk);
    in_valid = v;
    in       = m;
    code     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, M0, 3'b011);
    tests++; if (out !== 26'h0) begin fails++; $display("FAIL reset_out got=%h exp=%h", out, 26'h0); end
    tests++; if (neg !== 1'b0) begin fails++; $display("FAIL reset_neg got=%b exp=0", neg); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    drive(1'b0, M0, 3'b011);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
    tests++; if (out !== 26'h0) begin fails++; $display("FAIL post_reset_out got=%h exp=%h", out, 26'h0); end
  endtask

  task automatic test_positive;
    drive(1'b1, M0, 3'b001);
    tests++; if (out !== 26'h005AF0C || neg !== 1'b0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL pos_001 got=%h/%b/%b exp=005af0c/0/1", out, neg, out_valid); end
    drive(1'b1, M0, 3'b010);
    tests++; if (out !== 26'h005AF0C || neg !== 1'b0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL pos_010 got=%h/%b/%b exp=005af0c/0/1", out, neg, out_valid); end
    drive(1'b1, M0, 3'b011);
    tests++; if (out !== 26'h00B5E18 || neg !== 1'b0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL pos_011 got=%h/%b/%b exp=00b5e18/0/1", out, neg, out_valid); end
  endtask

  task automatic test_negative;
    drive(1'b1, M0, 3'b101);
    tests++; if (out !== NEG_M || neg !== 1'b1) begin
      fails++; $display("FAIL neg_101 got=%h/%b exp=%h/1", out, neg, NEG_M); end
    drive(1'b1, M0, 3'b110);
    tests++; if (out !== NEG_M || neg !== 1'b1) begin
      fails++; $display("FAIL neg_110 got=%h/%b exp=%h/1", out, neg, NEG_M); end
    drive(1'b1, M0, 3'b100);
    tests++; if (out !== NEG_2M || neg !== 1'b1) begin
      fails++; $display("FAIL neg_100 got=%h/%b exp=%h/1", out, neg, NEG_2M); end
`ifndef BOOTH_INV_ONLY_EN
    drive(1'b1, 23'h0, 3'b100);
    tests++; if (out !== 26'h0 || neg !== 1'b1) begin
      fails++; $display("FAIL neg_zero_m got=%h/%b exp=0000000/1", out, neg); end
`endif
  endtask

  task automatic test_zero_codes;
    drive(1'b1, MX, 3'b000);
    tests++; if (out !== 26'h0 || neg !== 1'b0) begin
      fails++; $display("FAIL zero_000 got=%h/%b exp=0000000/0", out, neg); end
    drive(1'b1, MX, 3'b111);
    tests++; if (out !== 26'h0 || neg !== 1'b0) begin
      fails++; $display("FAIL zero_111 got=%h/%b exp=0000000/0", out, neg); end
  endtask

  task automatic test_extremes;
    drive(1'b1, MX, 3'b100);
    tests++; if (out !== NEG_2MX || neg !== 1'b1) begin
      fails++; $display("FAIL ext_100 got=%h/%b exp=%h/1", out, neg, NEG_2MX); end
    drive(1'b1, MX, 3'b011);
    tests++; if (out !== 26'h0FFFFFE || neg !== 1'b0) begin
      fails++; $display("FAIL ext_011 got=%h/%b exp=0fffffe/0", out, neg); end
  endtask

  task automatic test_back_to_back;
    logic [OUT_W-1:0] exp_out [8];
    logic             exp_neg [8];
    exp_out = '{26'h0, 26'h005AF0C, 26'h005AF0C, 26'h00B5E18, NEG_2M, NEG_M, NEG_M, 26'h0};
    exp_neg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, M0, 3'(i));
      tests++; if (out !== exp_out[i] || neg !== exp_neg[i] || out_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_code%0d got=%h/%b/%b exp=%h/%b/1", i, out, neg, out_valid, exp_out[i], exp_neg[i]); end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, M0, 3'b101);
    drive(1'b0, MX, 3'b011);
    tests++; if (out_valid !== 1'b0 || out !== NEG_M || neg !== 1'b1) begin
      fails++; $display("FAIL hold_1 got=%h/%b/%b exp=%h/1/0", out, neg, out_valid, NEG_M); end
    drive(1'b0, 23'h0, 3'b001);
    tests++; if (out_valid !== 1'b0 || out !== NEG_M || neg !== 1'b1) begin
      fails++; $display("FAIL hold_2 got=%h/%b/%b exp=%h/1/0", out, neg, out_valid, NEG_M); end
  endtask

  task automatic test_reset_wins;
    rst_n = 1'b0;
    drive(1'b1, MX, 3'b100);
    tests++; if (out_valid !== 1'b0 || out !== 26'h0 || neg !== 1'b0) begin
      fails++; $display("FAIL reset_wins got=%h/%b/%b exp=0000000/0/0", out, neg, out_valid); end
    rst_n = 1'b1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in       = '0;
    code     = 3'b000;
    test_reset;
    test_positive;
    test_negative;
    test_zero_codes;
    test_extremes;
    test_back_to_back;
    test_hold;
    test_reset_wins;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
